// File: rtl/dp_ctrl_pkg.sv
// dp_ctrl_pkg: sequencer states, 5-bit opcode constants and IR field positions
package dp_ctrl_pkg;
    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, ERR} state_t;
    localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_AND = 5'b00010, OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SHR = 5'b00100, OP_SHL = 5'b00101, OP_ROR = 5'b00110, OP_ROL = 5'b00111;
    localparam logic [4:0] OP_MUL = 5'b01110, OP_DIV = 5'b01111;
    localparam int OP_MSB = 31, OP_LSB = 27, RA_MSB = 26, RA_LSB = 23;
    localparam int RB_MSB = 22, RB_LSB = 19, RC_MSB = 18, RC_LSB = 15;
    function automatic logic is_alu3(input logic [4:0] op);
        return op <= OP_ROL;
    endfunction
    function automatic logic is_muldiv(input logic [4:0] op);
        return op == OP_MUL || op == OP_DIV;
    endfunction
endpackage

// File: rtl/datapath_sequencer_if.sv
// datapath_sequencer_if: request inputs and datapath strobes; icount exists only with SEQ_ICOUNT_EN
interface datapath_sequencer_if;
    logic start, mem_ready;
    logic [31:0] ir;
    logic PCout, MARin, PCin, IncPC, Read, MDRin, MDRout, IRin;
    logic Yin, ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin;
    logic [4:0] opcode;
    logic [15:0] Rin, Rout;
    logic busy, done, illegal;
`ifdef SEQ_ICOUNT_EN
    logic [15:0] icount;
`endif
    modport master(
        input start, mem_ready, ir,
        output PCout, MARin, PCin, IncPC, Read, MDRin, MDRout, IRin,
        output Yin, ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin,
        output opcode, Rin, Rout, busy, done, illegal
`ifdef SEQ_ICOUNT_EN
        , output icount
`endif
    );
    modport slave(
        output start, mem_ready, ir,
        input PCout, MARin, PCin, IncPC, Read, MDRin, MDRout, IRin,
        input Yin, ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin,
        input opcode, Rin, Rout, busy, done, illegal
`ifdef SEQ_ICOUNT_EN
        , input icount
`endif
    );
endinterface

// File: rtl/reg_sel_decoder.sv
// reg_sel_decoder: 4-bit register field plus enable to a 16-bit one-hot select
module reg_sel_decoder (
    input  logic [3:0]  sel,
    input  logic        en,
    output logic [15:0] onehot
);
    assign onehot = en ? 16'h1 << sel : '0;
endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: T0..T6 control sequencer with registered strobes; SEQ_ICOUNT_EN adds a retired-instruction counter
module datapath_sequencer
    import dp_ctrl_pkg::*;
(
    input logic clock,
    input logic clear,
    datapath_sequencer_if.master bus
);
    state_t state, nxt;
    logic [4:0] op;
    logic [3:0] ra, rb, rc, rout_sel;
    logic alu3, muldiv, rout_en, rin_en, done_n, unused_ir;
    logic [15:0] rin_n, rout_n;
    assign op = bus.ir[OP_MSB:OP_LSB];
    assign ra = bus.ir[RA_MSB:RA_LSB];
    assign rb = bus.ir[RB_MSB:RB_LSB];
    assign rc = bus.ir[RC_MSB:RC_LSB];
    assign unused_ir = ^bus.ir[RC_LSB-1:0];
    assign alu3 = is_alu3(op);
    assign muldiv = is_muldiv(op);
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE: nxt = bus.start ? T0 : IDLE;
            T0: nxt = T1;
            T1: nxt = bus.mem_ready ? T2 : T1;
            T2: nxt = T3;
            T3: nxt = (alu3 || muldiv) ? T4 : ERR;
            T4: nxt = T5;
            T5: nxt = muldiv ? T6 : IDLE;
            default: nxt = IDLE;
        endcase
    end
    // Strobes are decoded from the next state and registered, so ir must be stable when T3 is entered
    assign rout_en = (nxt == T3 && (alu3 || muldiv)) || nxt == T4;
    assign rout_sel = nxt == T3 ? (muldiv ? ra : rb) : (muldiv ? rb : rc);
    assign rin_en = nxt == T5 && alu3;
    assign done_n = (nxt == T5 && alu3) || nxt == T6;
    reg_sel_decoder u_rin (.sel(ra), .en(rin_en), .onehot(rin_n));
    reg_sel_decoder u_rout (.sel(rout_sel), .en(rout_en), .onehot(rout_n));
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
            {bus.PCout, bus.MARin, bus.PCin, bus.IncPC, bus.Read, bus.MDRin, bus.MDRout, bus.IRin} <= '0;
            {bus.Yin, bus.ZLowIn, bus.ZHighIn, bus.Zlowout, bus.Zhighout, bus.HIin, bus.LOin} <= '0;
            bus.opcode <= '0;
            bus.Rin <= '0;
            bus.Rout <= '0;
            {bus.busy, bus.done, bus.illegal} <= '0;
        end else begin
            state <= nxt;
            bus.PCout <= nxt == T0;
            bus.MARin <= nxt == T0;
            bus.PCin <= nxt == T0;
            bus.IncPC <= nxt == T0;
            bus.Read <= nxt == T1;
            bus.MDRin <= nxt == T1;
            bus.MDRout <= nxt == T2;
            bus.IRin <= nxt == T2;
            bus.Yin <= nxt == T3 && (alu3 || muldiv);
            bus.ZLowIn <= nxt == T4;
            bus.ZHighIn <= nxt == T4 && muldiv;
            bus.opcode <= nxt == T4 ? op : '0;
            bus.Zlowout <= nxt == T5;
            bus.LOin <= nxt == T5 && muldiv;
            bus.Zhighout <= nxt == T6;
            bus.HIin <= nxt == T6;
            bus.Rin <= rin_n;
            bus.Rout <= rout_n;
            bus.busy <= nxt != IDLE;
            bus.done <= done_n;
            bus.illegal <= nxt == ERR;
        end
    end
`ifdef SEQ_ICOUNT_EN
    logic [15:0] icount_q;
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) icount_q <= '0;
        else if (done_n) icount_q <= icount_q + 16'd1;
    end
    assign bus.icount = icount_q;
`endif
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: scoreboard of expected per-cycle strobe snapshots for directed instructions
module tb_datapath_sequencer;
    typedef struct packed {
        logic busy, done, illegal, PCout, MARin, PCin, IncPC, Read, MDRin, MDRout, IRin;
        logic Yin, ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin;
        logic [4:0] opcode;
        logic [15:0] rin, rout;
    } snap_t;

    logic clock = 0;
    logic clear = 0;
    int total = 0;
    int fails = 0;
    snap_t exp_q[$];
    logic [15:0] exp_icount = '0;

    datapath_sequencer_if bus();
    datapath_sequencer dut (.clock(clock), .clear(clear), .bus(bus));

    always #5 clock = ~clock;

    function automatic snap_t sample();
        snap_t s;
        s = '0;
        {s.busy, s.done, s.illegal} = {bus.busy, bus.done, bus.illegal};
        {s.PCout, s.MARin, s.PCin, s.IncPC} = {bus.PCout, bus.MARin, bus.PCin, bus.IncPC};
        {s.Read, s.MDRin, s.MDRout, s.IRin} = {bus.Read, bus.MDRin, bus.MDRout, bus.IRin};
        {s.Yin, s.ZLowIn, s.ZHighIn, s.Zlowout} = {bus.Yin, bus.ZLowIn, bus.ZHighIn, bus.Zlowout};
        {s.Zhighout, s.HIin, s.LOin} = {bus.Zhighout, bus.HIin, bus.LOin};
        s.opcode = bus.opcode;
        s.rin = bus.Rin;
        s.rout = bus.Rout;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input string name, input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input int waits, input bit poke);
        snap_t s;
        bit a3, md;
        int n, lat, done_cyc;
        a3 = op <= 5'd7;
        md = op == 5'd14 || op == 5'd15;
        s = '0; s.busy = 1; s.PCout = 1; s.MARin = 1; s.PCin = 1; s.IncPC = 1; exp_q.push_back(s);
        s = '0; s.busy = 1; s.Read = 1; s.MDRin = 1;
        repeat (waits + 1) exp_q.push_back(s);
        s = '0; s.busy = 1; s.MDRout = 1; s.IRin = 1; exp_q.push_back(s);
        if (a3 || md) begin
            s = '0; s.busy = 1; s.Yin = 1; s.rout = 16'h1 << (md ? a : b); exp_q.push_back(s);
            s = '0; s.busy = 1; s.ZLowIn = 1; s.ZHighIn = md; s.opcode = op;
            s.rout = 16'h1 << (md ? b : c); exp_q.push_back(s);
            s = '0; s.busy = 1; s.Zlowout = 1; s.LOin = md; s.done = !md;
            s.rin = md ? 16'h0 : 16'h1 << a; exp_q.push_back(s);
            if (md) begin
                s = '0; s.busy = 1; s.Zhighout = 1; s.HIin = 1; s.done = 1; exp_q.push_back(s);
            end
        end else begin
            s = '0; s.busy = 1; exp_q.push_back(s);
            s.illegal = 1; exp_q.push_back(s);
        end
        s = '0; exp_q.push_back(s);
        lat = (a3 || md) ? (md ? 7 : 6) + waits : -1;
        @(negedge clock);
        bus.ir = {op, a, b, c, 15'h0};
        bus.mem_ready = waits == 0;
        bus.start = 1;
        n = exp_q.size();
        done_cyc = -1;
        for (int cyc = 1; cyc <= n; cyc++) begin
            @(posedge clock);
            #1;
            bus.start = poke && cyc == 3;
            bus.mem_ready = cyc >= 2 + waits;
            chk($sformatf("%s cyc%0d", name, cyc), sample(), exp_q.pop_front());
            if (bus.done && done_cyc < 0) done_cyc = cyc;
        end
        chk({name, " done_cycle"}, done_cyc, lat);
`ifdef SEQ_ICOUNT_EN
        if (a3 || md) exp_icount++;
        chk({name, " icount"}, bus.icount, exp_icount);
`endif
    endtask

    initial begin
        bus.start = 0;
        bus.mem_ready = 1;
        bus.ir = '0;
        #12;
        chk("reset_outputs", sample(), '0);
`ifdef SEQ_ICOUNT_EN
        chk("reset_icount", bus.icount, 16'h0);
`endif
        @(negedge clock);
        clear = 1;
        run("div_r2_r6", 5'b01111, 4'd2, 4'd6, 4'd0, 0, 0);
        run("add_1_2_3", 5'b00000, 4'd1, 4'd2, 4'd3, 0, 1);
        run("add_wait3", 5'b00000, 4'd1, 4'd2, 4'd3, 3, 0);
        run("illegal", 5'b11111, 4'd5, 4'd6, 4'd7, 0, 0);
        run("mul_wait1", 5'b01110, 4'd15, 4'd0, 4'd7, 1, 1);
        run("rol_edge", 5'b00111, 4'd0, 4'd15, 4'd8, 0, 0);
        run("sub_4_5_6", 5'b00001, 4'd4, 4'd5, 4'd6, 2, 0);
        run("illegal_10000", 5'b10000, 4'd1, 4'd1, 4'd1, 0, 0);
        @(negedge clock);
        bus.ir = {5'b00000, 4'd1, 4'd2, 4'd3, 15'h0};
        bus.mem_ready = 1;
        bus.start = 1;
        @(posedge clock);
        #1;
        bus.start = 0;
        repeat (4) @(posedge clock);
        #1;
        chk("t4_before_clear", {bus.ZLowIn, bus.Rout}, {1'b1, 16'h0008});
        clear = 0;
        #1;
        chk("clear_mid_t4", sample(), '0);
`ifdef SEQ_ICOUNT_EN
        exp_icount = '0;
        chk("clear_icount", bus.icount, exp_icount);
`endif
        @(negedge clock);
        clear = 1;
        bus.start = 1;
        @(posedge clock);
        #1;
        bus.start = 0;
        chk("t0_after_release", {bus.busy, bus.PCout, bus.MARin, bus.PCin, bus.IncPC}, 5'b11111);
        for (int i = 0; i < 20 && bus.busy; i++) @(posedge clock);
        #1;
        chk("idle_after_release_run", bus.busy, 1'b0);
`ifdef SEQ_ICOUNT_EN
        exp_icount++;
        chk("icount_release_run", bus.icount, exp_icount);
        @(negedge clock);
        force dut.icount_q = 16'hFFFF;
        #1;
        release dut.icount_q;
        exp_icount = 16'hFFFF;
        run("add_wrap", 5'b00000, 4'd1, 4'd2, 4'd3, 0, 1);
        chk("icount_wrapped", bus.icount, 16'h0000);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
        $finish;
    end
endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 The block SHALL have a `clock` input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have a `clear` input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have a `start` input, 1 bit: request to execute one instruction; sampled only in IDLE.
REQ-004 The block SHALL have a `mem_ready` input, 1 bit: memory read data valid on Mdatain.
REQ-005 The block SHALL have an `ir` input, 32 bits: current IR contents; fields opcode[31:27], ra[26:23], rb[22:19], rc[18:15].
REQ-006 The block SHALL have outputs `PCout`, `MARin`, `PCin`, `IncPC`, 1 bit each: fetch strobes to the datapath.
REQ-007 The block SHALL have outputs `Read`, `MDRin`, `MDRout`, `IRin`, 1 bit each: memory and IR strobes.
REQ-008 The block SHALL have outputs `Yin`, `ZLowIn`, `ZHighIn`, `Zlowout`, `Zhighout`, `HIin`, `LOin`, 1 bit each: ALU/result strobes.
REQ-009 The block SHALL have an `opcode` output, 5 bits: ALU operation select; 0 when not in T4.
REQ-010 The block SHALL have outputs `Rin` and `Rout`, 16 bits each: one-hot register-file load/drive selects (bit n = Rn).
REQ-011 The block SHALL have outputs `busy`, `done`, `illegal`, 1 bit each: status.
REQ-012 With SEQ_ICOUNT_EN defined, the block SHALL have an `icount` output, 16 bits: retired instruction count.

Function
REQ-013 The FSM SHALL have exactly these states: IDLE, T0, T1, T2, T3, T4, T5, T6, ERR.
REQ-014 In IDLE with start=1, the FSM SHALL go to T0 on the next edge; start with busy=1 SHALL be ignored.
REQ-015 T0 SHALL assert PCout, MARin, IncPC and PCin for one cycle, then go to T1.
REQ-016 T1 SHALL assert Read and MDRin and hold in T1 while mem_ready=0; mem_ready=1 SHALL go to T2 (one cycle if already high).
REQ-017 T2 SHALL assert MDRout and IRin, then go to T3; the ir fields SHALL be decoded from T3 onward.
REQ-018 For a three-register op (ADD, SUB, AND, OR, SHR, SHL, ROR, ROL), T3 SHALL assert Rout[rb] and Yin.
REQ-019 For a three-register op, T4 SHALL assert Rout[rc], opcode=ir[31:27] and ZLowIn.
REQ-020 For a three-register op, T5 SHALL assert Zlowout and Rin[ra], together with done, then go to IDLE.
REQ-021 For MUL and DIV, T3 SHALL assert Rout[ra] and Yin.
REQ-022 For MUL and DIV, T4 SHALL assert Rout[rb], opcode, ZLowIn and ZHighIn.
REQ-023 For MUL and DIV, T5 SHALL assert Zlowout and LOin.
REQ-024 For MUL and DIV, T6 SHALL assert Zhighout, HIin and done, then go to IDLE.
REQ-025 Latency from start to done SHALL be 6 cycles for three-register ops and 7 cycles for MUL/DIV, plus one cycle per T1 wait.
REQ-026 An opcode not listed in the package table SHALL cause T3 to go to ERR with no strobe asserted.
REQ-027 ERR SHALL assert illegal for one cycle, then go to IDLE; illegal SHALL NOT assert done.
REQ-028 All strobe outputs SHALL be registered (driven from the state register); no glitches on any strobe.
REQ-029 At most one bit of Rin and at most one bit of Rout SHALL be set in any cycle.
REQ-030 busy SHALL be 1 in T0..T6 and ERR, and 0 in IDLE.

Reset
REQ-031 clear=0 SHALL force IDLE asynchronously, in any state including mid-instruction.
REQ-032 During reset, all strobes, opcode, Rin, Rout, busy, done and illegal SHALL be 0, and icount SHALL be 0.
REQ-033 After clear is released, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-034 With SEQ_ICOUNT_EN defined, icount SHALL increment by 1 on every done pulse and wrap from 0xFFFF to 0x0000; illegal SHALL NOT count.
REQ-035 Without SEQ_ICOUNT_EN, the icount port and counter SHALL be absent.

Structure
REQ-036 The package dp_ctrl_pkg SHALL hold the state enum, the 5-bit opcode constants (ADD 00000 .. ROL 00111, MUL 01110, DIV 01111) and the IR field bit positions.
REQ-037 The block SHALL contain one sub-module, reg_sel_decoder: a 4-bit field plus enable to a 16-bit one-hot output, instantiated for Rin and Rout.

Verification
REQ-038 The bench SHALL run: R6=3, R2=0x12, ir=DIV ra=2 rb=6, mem_ready tied 1 -> T3 Rout=0x0004, T4 Rout=0x0040, opcode=01111, LOin then HIin, done at cycle 7.
REQ-039 The bench SHALL run: ADD ra=1 rb=2 rc=3 -> Rout=0x0004 in T3, Rout=0x0008 in T4, Rin=0x0002 in T5 with done, 6 cycles.
REQ-040 The bench SHALL run: mem_ready held 0 for 3 cycles in T1 -> Read/MDRin held 4 cycles, done at cycle 9.
REQ-041 The bench SHALL run: ir opcode=11111 -> illegal pulses once, no Rin/Rout bits set, back in IDLE, icount unchanged.
REQ-042 The bench SHALL run: clear=0 asserted in T4 -> all outputs 0 immediately; start after release -> T0 next edge.
REQ-043 The bench SHALL run (SEQ_ICOUNT_EN): icount preloaded 0xFFFF by forcing, then one ADD -> icount=0x0000; start pulsed while busy -> ignored.
